// File: rtl/grf_write_arbiter_if.sv
// Writeback handshake bundle: two requesters in, one register-file write port out.
interface grf_write_arbiter_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    logic              req0_valid;
    logic              req0_ready;
    logic [ADDR_W-1:0] req0_addr;
    logic [DATA_W-1:0] req0_data;
    logic              req1_valid;
    logic              req1_ready;
    logic [ADDR_W-1:0] req1_addr;
    logic [DATA_W-1:0] req1_data;
    logic              grf_we;
    logic [ADDR_W-1:0] grf_waddr;
    logic [DATA_W-1:0] grf_wdata;

    modport master (
        output req0_valid, req0_addr, req0_data,
        output req1_valid, req1_addr, req1_data,
        input  req0_ready, req1_ready,
        input  grf_we, grf_waddr, grf_wdata
    );

    modport slave (
        input  req0_valid, req0_addr, req0_data,
        input  req1_valid, req1_addr, req1_data,
        output req0_ready, req1_ready,
        output grf_we, grf_waddr, grf_wdata
    );
endinterface

// File: rtl/grf_write_arbiter.sv
// Round-robin arbiter for the register-file write port, with a per-register
// pending-write scoreboard that issue logic queries for outstanding writes.
module grf_write_arbiter #(
    parameter int GRF_SIZE = 32,
    parameter int CNT_W    = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    grf_write_arbiter_if.slave   bus,
    input  logic                 reserve_en,
    input  logic [4:0]           reserve_addr,
    input  logic [4:0]           query_addr0,
    input  logic [4:0]           query_addr1,
    output logic                 query_busy0,
    output logic                 query_busy1,
    output logic                 overflow
);
    localparam int ADDR_W = 5;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic             rr_q, rr_d;
    logic             overflow_q, overflow_d;
    logic [CNT_W-1:0] cnt_q [GRF_SIZE];
    logic [CNT_W-1:0] cnt_d [GRF_SIZE];

    logic              gnt0, gnt1, g_any;
    logic [ADDR_W-1:0] g_addr;
    logic [31:0]       g_data;

    // rr_q names the requester that wins the next contention.
    always_comb begin
        gnt0   = bus.req0_valid && (!bus.req1_valid || !rr_q);
        gnt1   = bus.req1_valid && (!bus.req0_valid ||  rr_q);
        g_any  = gnt0 || gnt1;
        g_addr = gnt1 ? bus.req1_addr : bus.req0_addr;
        g_data = gnt1 ? bus.req1_data : bus.req0_data;
        rr_d   = (bus.req0_valid && bus.req1_valid) ? !rr_q : rr_q;
    end

    always_comb begin
        bus.req0_ready = gnt0;
        bus.req1_ready = gnt1;
        bus.grf_we     = g_any && (g_addr != '0);
        bus.grf_waddr  = g_any ? g_addr : '0;
        bus.grf_wdata  = g_any ? g_data : '0;
    end

    // Entry 0 is never touched, so r0 always reads as idle.
    always_comb begin
        cnt_d      = cnt_q;
        overflow_d = overflow_q;
        for (int i = 1; i < GRF_SIZE; i++) begin
            if (reserve_en && (reserve_addr == ADDR_W'(i)) &&
                !(g_any && (g_addr == ADDR_W'(i)))) begin
                if (cnt_q[i] == CNT_MAX)
                    overflow_d = 1'b1;
                else
                    cnt_d[i] = cnt_q[i] + 1'b1;
            end else if (g_any && (g_addr == ADDR_W'(i)) &&
                         !(reserve_en && (reserve_addr == ADDR_W'(i)))) begin
                if (cnt_q[i] != '0)
                    cnt_d[i] = cnt_q[i] - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_q       <= 1'b0;
            overflow_q <= 1'b0;
            cnt_q      <= '{default: '0};
        end else begin
            rr_q       <= rr_d;
            overflow_q <= overflow_d;
            cnt_q      <= cnt_d;
        end
    end

    assign query_busy0 = (cnt_q[query_addr0] != '0);
    assign query_busy1 = (cnt_q[query_addr1] != '0);
    assign overflow    = overflow_q;
endmodule

// File: tb/tb_grf_write_arbiter.sv
// Directed stimulus with a per-cycle expectation queue checked by an independent monitor.
module tb_grf_write_arbiter;
    logic clk = 1'b0;
    logic reset;
    logic reserve_en;
    logic [4:0] reserve_addr, query_addr0, query_addr1;
    logic query_busy0, query_busy1, overflow;

    grf_write_arbiter_if bus ();

    grf_write_arbiter dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus.slave),
        .reserve_en   (reserve_en),
        .reserve_addr (reserve_addr),
        .query_addr0  (query_addr0),
        .query_addr1  (query_addr1),
        .query_busy0  (query_busy0),
        .query_busy1  (query_busy1),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        r0;
        logic        r1;
        logic        we;
        logic        chk_bus;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        b0;
        logic        b1;
        logic        ovf;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    function automatic exp_t mk(logic r0, logic r1, logic we, logic chk_bus,
                                logic [4:0] wa, logic [31:0] wd,
                                logic b0, logic b1, logic ovf);
        exp_t e;
        e.r0 = r0; e.r1 = r1; e.we = we; e.chk_bus = chk_bus;
        e.wa = wa; e.wd = wd; e.b0 = b0; e.b1 = b1; e.ovf = ovf;
        return e;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: every cycle that has an expectation queued is compared mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("req0_ready", 32'(bus.req0_ready), 32'(e.r0));
            chk("req1_ready", 32'(bus.req1_ready), 32'(e.r1));
            chk("one_ready",  32'(bus.req0_ready & bus.req1_ready), 32'd0);
            chk("grf_we",     32'(bus.grf_we), 32'(e.we));
            if (e.chk_bus) begin
                chk("grf_waddr", 32'(bus.grf_waddr), 32'(e.wa));
                chk("grf_wdata", bus.grf_wdata, e.wd);
            end
            chk("query_busy0", 32'(query_busy0), 32'(e.b0));
            chk("query_busy1", 32'(query_busy1), 32'(e.b1));
            chk("overflow",    32'(overflow), 32'(e.ovf));
        end
    end

    task automatic drive(logic v0, logic [4:0] a0, logic [31:0] d0,
                         logic v1, logic [4:0] a1, logic [31:0] d1,
                         logic ren, logic [4:0] ra, logic [4:0] q0, logic [4:0] q1);
        bus.req0_valid = v0; bus.req0_addr = a0; bus.req0_data = d0;
        bus.req1_valid = v1; bus.req1_addr = a1; bus.req1_data = d1;
        reserve_en = ren; reserve_addr = ra;
        query_addr0 = q0; query_addr1 = q1;
    endtask

    task automatic step(exp_t e);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state
        drive(0, 0, 0, 0, 0, 0, 0, 0, 5, 7);
        step(mk(0, 0, 0, 1, 5'd0, 32'h0, 0, 0, 0));

        // Contention alternates starting with req0
        drive(1, 5, 32'h11, 1, 6, 32'h22, 0, 0, 5, 6);
        step(mk(1, 0, 1, 1, 5'd5, 32'h11, 0, 0, 0));
        step(mk(0, 1, 1, 1, 5'd6, 32'h22, 0, 0, 0));
        step(mk(1, 0, 1, 1, 5'd5, 32'h11, 0, 0, 0));
        step(mk(0, 1, 1, 1, 5'd6, 32'h22, 0, 0, 0));

        // Lone req1 does not move the pointer; next contention goes to req0
        drive(0, 0, 0, 1, 9, 32'hDEADBEEF, 0, 0, 9, 0);
        step(mk(0, 1, 1, 1, 5'd9, 32'hDEADBEEF, 0, 0, 0));
        drive(1, 10, 32'hA0, 1, 11, 32'hB0, 0, 0, 10, 11);
        step(mk(1, 0, 1, 1, 5'd10, 32'hA0, 0, 0, 0));

        // Two reservations of r7 retired by two writes
        drive(0, 0, 0, 0, 0, 0, 1, 7, 7, 0);
        step(mk(0, 0, 0, 1, 5'd0, 32'h0, 0, 0, 0));
        step(mk(0, 0, 0, 1, 5'd0, 32'h0, 1, 0, 0));
        drive(0, 0, 0, 0, 0, 0, 0, 0, 7, 0);
        step(mk(0, 0, 0, 1, 5'd0, 32'h0, 1, 0, 0));
        drive(1, 7, 32'h77, 0, 0, 0, 0, 0, 7, 0);
        step(mk(1, 0, 1, 1, 5'd7, 32'h77, 1, 0, 0));
        drive(0, 0, 0, 1, 7, 32'h78, 0, 0, 7, 0);
        step(mk(0, 1, 1, 1, 5'd7, 32'h78, 1, 0, 0));
        drive(0, 0, 0, 0, 0, 0, 0, 0, 7, 0);
        step(mk(0, 0, 0, 1, 5'd0, 32'h0, 0, 0, 0));

        // Same-cycle reserve and retire of r3 leaves the count at 1
        drive(0, 0, 0, 0, 0, 0, 1, 3, 0, 3);
        step(mk(0, 0, 0, 1, 5'd0, 32'h0, 0, 0, 0));
        drive(1, 3, 32'h33, 0, 0, 0, 1, 3, 0, 3);
        step(mk(1, 0, 1, 1, 5'd3, 32'h33, 0, 1, 0));
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 3);
        step(mk(0, 0, 0, 1, 5'd0, 32'h0, 0, 1, 0));

        // Write to r0 is accepted without a register-file write; r0 reservation ignored
        drive(0, 0, 0, 1, 0, 32'h55, 1, 0, 0, 3);
        step(mk(0, 1, 0, 0, 5'd0, 32'h0, 0, 1, 0));
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 3);
        step(mk(0, 0, 0, 1, 5'd0, 32'h0, 0, 1, 0));

        // Four reservations of r4: the fourth saturates and sets overflow
        drive(0, 0, 0, 0, 0, 0, 1, 4, 4, 3);
        step(mk(0, 0, 0, 1, 5'd0, 32'h0, 0, 1, 0));
        step(mk(0, 0, 0, 1, 5'd0, 32'h0, 1, 1, 0));
        step(mk(0, 0, 0, 1, 5'd0, 32'h0, 1, 1, 0));
        step(mk(0, 0, 0, 1, 5'd0, 32'h0, 1, 1, 0));
        drive(0, 0, 0, 0, 0, 0, 0, 0, 4, 3);
        step(mk(0, 0, 0, 1, 5'd0, 32'h0, 1, 1, 1));

        // Reset during contention: pointer was at req1, cleared afterwards
        reset = 1'b1;
        drive(1, 12, 32'hC0, 1, 13, 32'hD0, 1, 4, 4, 3);
        step(mk(0, 1, 1, 1, 5'd13, 32'hD0, 1, 1, 1));
        reset = 1'b0;
        drive(1, 12, 32'hC0, 1, 13, 32'hD0, 0, 0, 4, 3);
        step(mk(1, 0, 1, 1, 5'd12, 32'hC0, 0, 0, 0));
        step(mk(0, 1, 1, 1, 5'd13, 32'hD0, 0, 0, 0));

        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/grf_write_arbiter.md
Name: grf_write_arbiter

Overview:
- Shares the register file's single write port between two writeback requesters: req0 = main pipeline WB, req1 = multi-cycle unit (mult/div, load).
- Uses valid/ready handshakes with round-robin arbitration.
- Keeps a per-register pending-write scoreboard so issue logic can tell whether a source register still has an outstanding write.
- Sits between the writeback sources and the register file write inputs (write_enable / write_addr / write_data).

Parameters:
- GRF_SIZE, 32, number of architectural registers; the scoreboard has one entry per register.
- CNT_W, 2, width of each per-register pending-write counter (max outstanding = 2^CNT_W - 1).

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  synchronous, active-high.
- req0_valid  input  1  requester 0 has a write.
- req0_ready  output  1  requester 0 write accepted this cycle.
- req0_addr  input  5  requester 0 destination register.
- req0_data  input  32  requester 0 write data.
- req1_valid  input  1  requester 1 has a write.
- req1_ready  output  1  requester 1 write accepted this cycle.
- req1_addr  input  5  requester 1 destination register.
- req1_data  input  32  requester 1 write data.
- reserve_en  input  1  issue stage reserves a future write.
- reserve_addr  input  5  register being reserved.
- query_addr0  input  5  scoreboard query port 0.
- query_addr1  input  5  scoreboard query port 1.
- query_busy0  output  1  query_addr0 has pending writes.
- query_busy1  output  1  query_addr1 has pending writes.
- grf_we  output  1  to register file write_enable.
- grf_waddr  output  5  to register file write_addr.
- grf_wdata  output  32  to register file write_data.
- overflow  output  1  sticky: a reservation was dropped because its counter was saturated.

Behaviour:
- **Reset** (synchronous, active-high, clock clk):
  - rr_ptr = 0.
  - All pending counters = 0.
  - overflow = 0.
  - Reset overrides all same-edge activity.
- **Arbitration** (combinational within the cycle):
  - Only one valid: grant it.
  - Both valid: grant the requester selected by rr_ptr.
  - Neither valid: no grant.
- **rr_ptr update:** flips to the non-granted requester at posedge, only in cycles where both were valid. Otherwise it holds.
- **Handshake:**
  - reqN_ready = granted N. At most one ready per cycle; ready is never asserted without its valid.
  - Transfer completes at the posedge where valid && ready.
  - A requester must hold addr/data stable while valid && !ready.
- **Write port:**
  - Granted and addr != 0: grf_we = 1; grf_waddr/grf_wdata = granted request.
  - Granted with addr == 0: accepted (ready = 1) but grf_we = 0.
  - No grant: grf_we = 0, grf_waddr = 0, grf_wdata = 0.
  - Latency is 0 cycles: the register file commits at the same posedge as the handshake.
- **Scoreboard**, one CNT_W-bit counter per register, updated at posedge:
  - inc = reserve_en && reserve_addr != 0.
  - dec = a transfer completes && granted addr != 0.
  - inc and dec on the same register: counter unchanged.
  - dec at 0: stays 0 (unreserved write is legal).
  - inc at max (3): counter unchanged, overflow set to 1 and held until reset.
  - Register 0 is never counted; query_busyN for address 0 is always 0.
- **Query:**
  - query_busyN = (counter[query_addrN] != 0).
  - Reflects registered state only; a same-cycle reserve or complete is visible the next cycle.
- Requester address range is 0..GRF_SIZE-1. Addresses >= GRF_SIZE are outside the contract.

Test Plan:
- Reset, then both valid for 4 cycles with req0_addr=5, req1_addr=6 → grants 0,1,0,1. grf_waddr sequence 5,6,5,6. Exactly one ready per cycle.
- req1 only valid, addr=9, data=32'hDEADBEEF → req1_ready=1 and grf_we=1 that cycle, waddr=9, wdata=DEADBEEF. rr_ptr unchanged (next contention grants req0).
- Reserve r7 twice (two cycles) → query_busy0(7)=1. First write to r7 completes: still busy. Second completes: busy=0 the following cycle.
- Same cycle: reserve r3 while r3 write completes, counter initially 1 → counter stays 1, busy=1. Separately, write with addr 0 → ready=1, grf_we=0, no counter change, query of r0 = 0.
- Reserve r4 four times → counter 3, overflow=1 after the 4th edge. Then assert reset mid-contention → the next cycle all counters = 0, overflow=0, rr_ptr=0, so req0 wins the next contention.
